rsa_modexp_serial: RTL and testbench

RSA_MODEXP_SERIAL -- requirements
Module: rsa_modexp_serial

---
 rtl/rsa_pkg.sv | 18 +
 rtl/modmul_serial.sv | 86 ++++++++
 rtl/rsa_modexp_serial.sv | 181 ++++++++++++++++++
 tb/tb_rsa_modexp_serial.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg -- shared definitions for the serial RSA modular exponentiator.
//   state_t     : top-level FSM encoding (IDLE, REDUCE, STEP, FINISH)
//   mm_latency  : cycles from a modmul_serial go pulse to its valid pulse
package rsa_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REDUCE = 2'd1,
      ST_STEP   = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   // One interleaved shift-add-subtract iteration per operand bit.
   function automatic int mm_latency(input int width);
      return width;
   endfunction

endpackage

// File: rtl/modmul_serial.sv
// modmul_serial -- bit-serial modular multiplier, p = a*b mod n.
// MSB-first interleaved shift-add-subtract: one bit of a per cycle, b is the
// addend. The accumulator stays below n between iterations, so the addend b
// must be below n; a may be any WIDTH-bit value (a = m, b = 1 reduces m).
// Ports:
//   clk, rst    : clock, synchronous active-high reset (returns to idle)
//   go          : one-cycle start; a, b, n sampled on that edge
//   a, b, n     : multiplier, addend/multiplicand, modulus
//   p           : product, stable from the valid cycle until the next go
//   valid       : one-cycle pulse exactly mm_latency(WIDTH) cycles after go
module modmul_serial
   import rsa_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] p,
   output logic             valid
);

   localparam int AW = WIDTH + 2;
   localparam int CW = $clog2(WIDTH + 1);

   logic [AW-1:0]    acc;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] n_r;
   logic [CW-1:0]    cnt;
   logic             running;

   // 2*acc + bit*b is below 3n when acc, b < n, so two conditional
   // subtractions bring it back under n without any divider.
   function automatic logic [AW-1:0] mm_step(input logic [AW-1:0]    acc_in,
                                             input logic             bit_in,
                                             input logic [WIDTH-1:0] addend,
                                             input logic [WIDTH-1:0] modulus);
      logic [AW-1:0] v;
      logic [AW-1:0] nn;
      nn = {2'b00, modulus};
      v  = {acc_in[AW-2:0], 1'b0} + (bit_in ? {2'b00, addend} : {AW{1'b0}});
      if (v >= nn) v = v - nn;
      if (v >= nn) v = v - nn;
      return v;
   endfunction

   // control: the go edge performs the first iteration, the remaining
   // WIDTH-1 iterations follow, and valid rises with the last one
   always_ff @(posedge clk) begin
      if (rst) begin
         running <= 1'b0;
         valid   <= 1'b0;
         cnt     <= '0;
      end else if (go) begin
         running <= 1'b1;
         valid   <= 1'b0;
         cnt     <= CW'(mm_latency(WIDTH) - 1);
      end else if (running) begin
         cnt   <= cnt - CW'(1);
         valid <= (cnt == CW'(1));
         if (cnt == CW'(1)) running <= 1'b0;
      end else begin
         valid <= 1'b0;
      end
   end

   // datapath
   always_ff @(posedge clk) begin
      if (go) begin
         acc  <= mm_step({AW{1'b0}}, a[WIDTH-1], b, n);
         a_sh <= {a[WIDTH-2:0], 1'b0};
         b_r  <= b;
         n_r  <= n;
      end else if (running) begin
         acc  <= mm_step(acc, a_sh[WIDTH-1], b_r, n_r);
         a_sh <= {a_sh[WIDTH-2:0], 1'b0};
      end
   end

   assign p = acc[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp_serial.sv
// rsa_modexp_serial -- out = m^e mod n, right-to-left binary exponentiation
// with two serial modular multipliers (square and multiply) run in parallel.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : request, accepted only in IDLE (wins over abort)
//   abort               : cancels an operation while busy
//   m_in, e_in, n_in    : message, exponent, modulus (sampled on accept)
//   out                 : result, held until the next done
//   busy                : high while REDUCE/STEP are running
//   done                : one-cycle completion pulse
//   err                 : qualifies done, high when n_in < 2 (out = 0)
module rsa_modexp_serial
   import rsa_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] m_in,
   input  logic [WIDTH-1:0] e_in,
   input  logic [WIDTH-1:0] n_in,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t           state;
   state_t           state_nxt;
   logic             go_r;
   logic             go_nxt;
   logic             accept;
   logic             kill;
   logic             reduce_done;
   logic             step_done;
   logic             last_step;

   logic [WIDTH-1:0] m_r;
   logic [WIDTH-1:0] e_r;
   logic [WIDTH-1:0] n_r;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] res;

   logic [WIDTH-1:0] sq_a;
   logic [WIDTH-1:0] sq_b;
   logic [WIDTH-1:0] sq_p;
   logic             sq_valid;
   logic [WIDTH-1:0] mul_p;
   logic             mul_valid;
   logic             mm_rst;
   logic             mul_go;

   // No exponent bits remain after the current one.
   assign last_step = ((e_r >> 1) == '0);

   always_comb begin
      state_nxt   = state;
      go_nxt      = 1'b0;
      accept      = 1'b0;
      kill        = 1'b0;
      reduce_done = 1'b0;
      step_done   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (n_in >= WIDTH'(2)) begin
                  state_nxt = ST_REDUCE;
                  go_nxt    = 1'b1;
               end else begin
                  state_nxt = ST_FINISH;
               end
            end
         end
         ST_REDUCE: begin
            if (abort) begin
               kill      = 1'b1;
               state_nxt = ST_IDLE;
            end else if (sq_valid) begin
               reduce_done = 1'b1;
               if (e_r == '0) begin
                  state_nxt = ST_FINISH;
               end else begin
                  state_nxt = ST_STEP;
                  go_nxt    = 1'b1;
               end
            end
         end
         ST_STEP: begin
            if (abort) begin
               kill      = 1'b1;
               state_nxt = ST_IDLE;
            end else if (sq_valid && mul_valid) begin
               step_done = 1'b1;
               if (last_step) state_nxt = ST_FINISH;
               else           go_nxt    = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         go_r  <= 1'b0;
         out   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         go_r  <= go_nxt;
         if (accept && (state_nxt == ST_FINISH)) begin
            out <= '0;
            err <= 1'b1;
         end else if (reduce_done && (e_r == '0)) begin
            out <= res;
            err <= 1'b0;
         end else if (step_done && last_step) begin
            out <= e_r[0] ? mul_p : res;
            err <= 1'b0;
         end
      end
   end

   // operand registers (no reset: only meaningful after an accept)
   always_ff @(posedge clk) begin
      if (accept) begin
         m_r <= m_in;
         e_r <= e_in;
         n_r <= n_in;
         res <= WIDTH'(1);
      end else if (step_done) begin
         if (e_r[0]) res <= mul_p;
         e_r <= e_r >> 1;
      end
      if (reduce_done || step_done) base <= sq_p;
   end

   assign busy = (state == ST_REDUCE) || (state == ST_STEP);
   assign done = (state == ST_FINISH);

   // REDUCE borrows the squarer to compute m*1 mod n (m scanned as the
   // multiplier, so m >= n is fine). Abort resets both multipliers so a
   // stale valid can never land in a restarted operation.
   always_comb begin
      sq_a = base;
      sq_b = base;
      if (state == ST_REDUCE) begin
         sq_a = m_r;
         sq_b = WIDTH'(1);
      end
   end

   assign mm_rst = rst | kill;
   assign mul_go = go_r & (state == ST_STEP);

   modmul_serial #(.WIDTH(WIDTH)) u_sq (
      .clk   (clk),
      .rst   (mm_rst),
      .go    (go_r),
      .a     (sq_a),
      .b     (sq_b),
      .n     (n_r),
      .p     (sq_p),
      .valid (sq_valid)
   );

   modmul_serial #(.WIDTH(WIDTH)) u_mul (
      .clk   (clk),
      .rst   (mm_rst),
      .go    (mul_go),
      .a     (res),
      .b     (base),
      .n     (n_r),
      .p     (mul_p),
      .valid (mul_valid)
   );

endmodule

// File: tb/tb_rsa_modexp_serial.sv
`timescale 1ns/1ps
module tb_rsa_modexp_serial;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [W-1:0] m_in = '0;
   logic [W-1:0] e_in = '0;
   logic [W-1:0] n_in = '0;
   logic [W-1:0] out;
   logic         busy;
   logic         done;
   logic         err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [W-1:0] out;
      logic         err;
      int           cyc;
      string        name;
   } exp_t;

   exp_t q[$];

   rsa_modexp_serial #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .abort (abort),
      .m_in  (m_in),
      .e_in  (e_in),
      .n_in  (n_in),
      .out   (out),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      if (q.size() > 0 && cyc > q[0].cyc) begin
         checks++;
         errors++;
         $display("FAIL %s missing_done: no done by cycle %0d (now %0d)", q[0].name, q[0].cyc, cyc);
         void'(q.pop_front());
      end
      if (done === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done at cycle %0d out=%0d err=%0d, required no done", cyc, out, err);
         end else begin
            exp_t x;
            x = q.pop_front();
            checks++;
            if (out !== x.out || err !== x.err || cyc != x.cyc) begin
               errors++;
               $display("FAIL %s: out=%0d err=%0d done_cyc=%0d, required out=%0d err=%0d done_cyc=%0d",
                        x.name, out, err, cyc, x.out, x.err, x.cyc);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   function automatic int bitlen(input logic [W-1:0] e);
      int k = 0;
      for (int i = 0; i < W; i++) if (e[i]) k = i + 1;
      return k;
   endfunction

   function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] m, input logic [W-1:0] e,
                                                input logic [W-1:0] n);
      longint r, b, nn, ee;
      nn = longint'(n);
      r  = 1 % nn;
      b  = longint'(m) % nn;
      ee = longint'(e);
      while (ee != 0) begin
         if (ee[0]) r = (r * b) % nn;
         b  = (b * b) % nn;
         ee = ee >> 1;
      end
      return W'(r);
   endfunction

   // Issues one operation starting at the current negedge, checks busy each
   // cycle and returns at the negedge after done (a new start is legal then).
   task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n,
                        input logic [W-1:0] eo, input logic ee, input string nm,
                        input bit disturb, input bit abort_too);
      int lat;
      exp_t x;
      lat = (n < 2) ? 1 : (bitlen(e) + 1) * (W + 1) + 1;
      start = 1'b1;
      abort = abort_too;
      m_in = m;
      e_in = e;
      n_in = n;
      x.out = eo;
      x.err = ee;
      x.cyc = cyc + lat;
      x.name = nm;
      q.push_back(x);
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start = 1'b0;
            abort = 1'b0;
         end
         if (disturb && c == 10) begin
            start = 1'b1;
            m_in = 16'd1234;
            e_in = 16'd3;
            n_in = 16'd999;
         end
         if (disturb && c == 11) start = 1'b0;
         check({nm, "_busy"}, W'(busy), W'((n >= 2) && (c < lat)));
      end
      @(negedge clk);
   endtask

   initial begin
      logic [W-1:0] rm, re, rn;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy", W'(busy), 0);
      check("rst_done", W'(done), 0);
      check("rst_err", W'(err), 0);
      check("rst_out", out, 0);
      rst = 1'b0;
      @(negedge clk);

      // directed vectors
      do_op(16'd65,    16'd17,   16'd3233,  16'd2790, 1'b0, "enc_65_17",   0, 0);
      do_op(16'd2790,  16'd2753, 16'd3233,  16'd65,   1'b0, "dec_2790",    0, 0);
      do_op(16'd3298,  16'd17,   16'd3233,  16'd2790, 1'b0, "m_ge_n",      0, 0);
      do_op(16'd1234,  16'd0,    16'd3233,  16'd1,    1'b0, "e_zero",      0, 0);
      do_op(16'd77,    16'd5,    16'd1,     16'd0,    1'b1, "n_one",       0, 0);
      do_op(16'd77,    16'd5,    16'd0,     16'd0,    1'b1, "n_zero",      0, 0);
      do_op(16'd4,     16'd13,   16'd497,   16'd445,  1'b0, "4_13_497",    0, 0);
      do_op(16'd2,     16'd10,   16'd1000,  16'd24,   1'b0, "start_abort", 0, 1);
      do_op(16'd65535, 16'd1,    16'd65535, 16'd0,    1'b0, "m_eq_n",      0, 0);
      do_op(16'd65535, 16'd2,    16'd65521, 16'd196,  1'b0, "big_n",       0, 0);
      do_op(16'd5,     16'd1,    16'd2,     16'd1,    1'b0, "n_two",       0, 0);

      // abort while idle is ignored
      abort = 1'b1;
      repeat (3) @(negedge clk);
      abort = 1'b0;
      check("idle_abort_busy", W'(busy), 0);
      check("idle_abort_out", out, 16'd1);
      @(negedge clk);

      // abort at cycle 40
      do_op(16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0, "pre_abort", 0, 0);
      start = 1'b1;
      m_in = 16'd65;
      e_in = 16'd17;
      n_in = 16'd3233;
      @(negedge clk);
      start = 1'b0;
      repeat (39) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", W'(busy), 0);
      check("abort_out", out, 16'd2790);
      check("abort_err", W'(err), 0);
      do_op(16'd4, 16'd13, 16'd497, 16'd445, 1'b0, "restart", 0, 0);

      // start pulses and input changes while busy are ignored
      do_op(16'd65, 16'd17, 16'd3233, 16'd2790, 1'b0, "disturb", 1, 0);

      // reset at cycle 50
      start = 1'b1;
      m_in = 16'd65;
      e_in = 16'd17;
      n_in = 16'd3233;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", W'(busy), 0);
      check("midrst_done", W'(done), 0);
      check("midrst_err", W'(err), 0);
      check("midrst_out", out, 0);
      repeat (80) @(negedge clk);

      // random regression against the bench model
      for (int i = 0; i < 150; i++) begin
         rm = W'($urandom);
         rn = W'($urandom_range(2, 65535));
         re = W'($urandom) & W'((32'd1 << $urandom_range(0, 16)) - 1);
         do_op(rm, re, rn, ref_modexp(rm, re, rn), 1'b0, "random", 0, 0);
      end

      repeat (5) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL pending_expect: %0d expected done pulses never seen, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
